// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the debug register-dump path: FSM state encoding
// and default sizing for the register-dump controller.
package mips_dbg_pkg;

  localparam int DBG_DATA_W       = 32;
  localparam int DBG_ADDR_W       = 5;
  localparam int DBG_HOLD_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_READ   = 3'd2,
    ST_CAPT   = 3'd3,
    ST_SEND   = 3'd4,
    ST_FINISH = 3'd5
  } dump_state_t;

endpackage

// File: rtl/dbg_out_reg.sv
// Valid/ready holding register for the dumped register stream. The word is
// held stable until accepted; flush drops it without a transfer.
module dbg_out_reg #(
  parameter int DATA_W = mips_dbg_pkg::DBG_DATA_W,
  parameter int ADDR_W = mips_dbg_pkg::DBG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic              load_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] idx,
  output logic              valid,
  output logic              last,
  output logic              xfer
);

  assign xfer = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
      idx   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
      data  <= load_data;
      idx   <= load_idx;
    end else if (xfer) begin
      // last is cleared with valid so it never lingers on an idle stream
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: freezes the pipeline via hold_req/hold_ack,
// reads registers first_reg..last_reg through the T port and streams them out.
module reg_dump_ctrl #(
  parameter int DATA_W       = mips_dbg_pkg::DBG_DATA_W,
  parameter int ADDR_W       = mips_dbg_pkg::DBG_ADDR_W,
  parameter int HOLD_TIMEOUT = mips_dbg_pkg::DBG_HOLD_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              hold_req,
  input  logic              hold_ack,
  output logic [ADDR_W-1:0] rf_T_addr,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_T_data,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import mips_dbg_pkg::*;

  localparam int CNT_W = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic [CNT_W-1:0]  hold_cnt;
  logic              out_load;
  logic              out_xfer;
  logic              abort_dump;
  logic              hold_timeout;
  logic              dump_complete;

  assign abort_dump    = ((state == ST_READ) || (state == ST_CAPT) || (state == ST_SEND)) && !hold_ack;
  assign hold_timeout  = (state == ST_HOLD) && !hold_ack && (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1));
  assign dump_complete = (state == ST_SEND) && hold_ack && out_xfer && (idx == last_idx);
  assign out_load      = (state == ST_CAPT) && hold_ack;

  // Every route into FINISH shares one exit path so done/err/hold_req line up with it
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      last_idx  <= '0;
      hold_cnt  <= '0;
      hold_req  <= 1'b0;
      rf_rd_en  <= 1'b0;
      rf_T_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort_dump || hold_timeout || dump_complete) begin
        state    <= ST_FINISH;
        hold_req <= 1'b0;
        busy     <= 1'b0;
        rf_rd_en <= 1'b0;
        done     <= 1'b1;
        err      <= !dump_complete;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dump_req) begin
              if (first_reg <= last_reg) begin
                idx      <= first_reg;
                last_idx <= last_reg;
                hold_cnt <= '0;
                hold_req <= 1'b1;
                busy     <= 1'b1;
                state    <= ST_HOLD;
              end else begin
                done <= 1'b1;
                err  <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (hold_ack) begin
              rf_rd_en  <= 1'b1;
              rf_T_addr <= idx;
              state     <= ST_READ;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_READ: begin
            rf_rd_en <= 1'b0;
            state    <= ST_CAPT;
          end
          ST_CAPT: state <= ST_SEND;
          ST_SEND: begin
            // completion at last_idx is handled above, so idx never wraps here
            if (out_xfer) begin
              idx       <= idx + 1'b1;
              rf_T_addr <= idx + 1'b1;
              rf_rd_en  <= 1'b1;
              state     <= ST_READ;
            end
          end
          ST_FINISH: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  dbg_out_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (out_load),
    .flush     (abort_dump),
    .load_data (rf_T_data),
    .load_idx  (idx),
    .load_last (idx == last_idx),
    .ready     (dout_ready),
    .data      (dout_data),
    .idx       (dout_idx),
    .valid     (dout_valid),
    .last      (dout_last),
    .xfer      (out_xfer)
  );

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: full dump, backpressure, bad range,
// hold timeout, abort, reset mid-dump and the idx-31 boundary.
module tb_reg_dump_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int HOLD_TIMEOUT = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              dump_req = 1'b0;
  logic [ADDR_W-1:0] first_reg = '0;
  logic [ADDR_W-1:0] last_reg = '0;
  logic              hold_req;
  logic              hold_ack = 1'b0;
  logic [ADDR_W-1:0] rf_T_addr;
  logic              rf_rd_en;
  logic [DATA_W-1:0] rf_T_data = '0;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_idx;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              dout_last;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_err = 0;

  logic [DATA_W-1:0] rf_mem [32];
  logic [ADDR_W-1:0] xq_idx [$];
  logic [DATA_W-1:0] xq_data [$];
  logic              xq_last [$];
  int rd_cnt, done_cnt, stall_cnt, stable_bad;
  logic hold_seen;
  logic stall_prev;
  logic [DATA_W-1:0] snap_data;
  logic [ADDR_W-1:0] snap_idx;
  logic snap_last;

  reg_dump_ctrl #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .dump_req   (dump_req),
    .first_reg  (first_reg),
    .last_reg   (last_reg),
    .hold_req   (hold_req),
    .hold_ack   (hold_ack),
    .rf_T_addr  (rf_T_addr),
    .rf_rd_en   (rf_rd_en),
    .rf_T_data  (rf_T_data),
    .dout_data  (dout_data),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  // Register file with one-cycle read latency on the T port
  always @(posedge sys_clk) if (rf_rd_en) rf_T_data <= rf_mem[rf_T_addr];

  // Stream monitor, sampled mid-cycle while inputs and outputs are stable
  always @(negedge sys_clk) begin
    if (rf_rd_en) rd_cnt++;
    if (hold_req) hold_seen = 1'b1;
    if (done) done_cnt++;
    if (stall_prev && dout_valid &&
        (dout_data !== snap_data || dout_idx !== snap_idx || dout_last !== snap_last))
      stable_bad++;
    stall_prev = dout_valid && !dout_ready;
    if (stall_prev) stall_cnt++;
    snap_data = dout_data;
    snap_idx  = dout_idx;
    snap_last = dout_last;
    if (dout_valid && dout_ready) begin
      xq_idx.push_back(dout_idx);
      xq_data.push_back(dout_data);
      xq_last.push_back(dout_last);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    xq_idx.delete();
    xq_data.delete();
    xq_last.delete();
    rd_cnt = 0;
    done_cnt = 0;
    stall_cnt = 0;
    stable_bad = 0;
    hold_seen = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic start(input int f, input int l);
    dump_req  = 1'b1;
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    tick();
    dump_req = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in three
  task automatic wait_done(input int max_cyc, input int mode,
                           output logic seen, output logic e, output int cyc);
    seen = 1'b0;
    e = 1'b0;
    cyc = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      dout_ready = (mode == 0) ? 1'b1 : ((c % 3) == 2);
      tick();
      if (done) begin
        seen = 1'b1;
        e = err;
        cyc = c + 1;
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] rval(input int i);
    return 32'(i) * 32'h1111_1111;
  endfunction

  initial begin
    logic seen, e;
    int cyc;
    for (int i = 0; i < 32; i++) rf_mem[i] = rval(i);
    clear_mon();

    // Reset state
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    chk("rst_outputs", {hold_req, rf_rd_en, dout_valid, dout_last, busy, done, err}, 64'd0);
    chk("rst_addr_idx", {rf_T_addr, dout_idx}, 64'd0);
    chk("rst_data", dout_data, 64'd0);

    // Full dump 0..15 with latency walk-through
    hold_ack = 1'b1;
    dout_ready = 1'b1;
    clear_mon();
    start(0, 15);
    chk("full_hold_busy", {hold_req, busy, rf_rd_en}, 64'b110);
    tick();
    chk("full_rd_en_first", {rf_rd_en, dout_valid}, 64'b10);
    chk("full_rd_addr_first", rf_T_addr, 64'd0);
    tick();
    chk("full_capt", {rf_rd_en, dout_valid}, 64'b00);
    tick();
    chk("full_valid_first", {dout_valid, dout_last}, 64'b10);
    chk("full_data_first", dout_data, rval(0));
    wait_done(200, 0, seen, e, cyc);
    chk("full_done", seen, 64'd1);
    chk("full_err", e, 64'd0);
    chk("full_release", {hold_req, busy}, 64'd0);
    chk("full_count", xq_idx.size(), 64'd16);
    chk("full_reads", rd_cnt, 64'd16);
    for (int i = 0; i < 16 && i < xq_idx.size(); i++) begin
      chk("full_idx", xq_idx[i], 64'(i));
      chk("full_data", xq_data[i], rval(i));
      chk("full_last", xq_last[i], 64'(i == 15));
    end
    tick();
    chk("full_done_pulse", {done, done_cnt}, {1'b0, 63'd1});

    // Backpressure 3..5
    dout_ready = 1'b0;
    clear_mon();
    start(3, 5);
    wait_done(200, 1, seen, e, cyc);
    chk("bp_done_err", {seen, e}, 64'b10);
    chk("bp_count", xq_idx.size(), 64'd3);
    for (int i = 0; i < 3 && i < xq_idx.size(); i++) begin
      chk("bp_idx", xq_idx[i], 64'(i + 3));
      chk("bp_data", xq_data[i], rval(i + 3));
      chk("bp_last", xq_last[i], 64'(i == 2));
    end
    chk("bp_stalled", stall_cnt > 0, 64'd1);
    chk("bp_stable", stable_bad, 64'd0);

    // Bad range 9..2
    tick();
    clear_mon();
    start(9, 2);
    chk("bad_done_err", {done, err}, 64'b11);
    chk("bad_no_hold", {hold_req, busy}, 64'd0);
    tick();
    chk("bad_pulse", done, 64'd0);
    tick();
    chk("bad_hold_seen", hold_seen, 64'd0);

    // Hold timeout
    hold_ack = 1'b0;
    clear_mon();
    start(0, 3);
    chk("to_hold_req", hold_req, 64'd1);
    wait_done(20, 0, seen, e, cyc);
    chk("to_done_err", {seen, e}, 64'b11);
    chk("to_cycles", cyc, 64'(HOLD_TIMEOUT));
    chk("to_release", {hold_req, busy}, 64'd0);
    chk("to_no_reads", rd_cnt, 64'd0);
    tick();
    chk("to_idle", {hold_req, busy, done}, 64'd0);

    // Abort by dropping hold_ack while idx 7 is presented
    hold_ack = 1'b1;
    dout_ready = 1'b1;
    clear_mon();
    start(0, 31);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (dout_valid && dout_idx == 5'd7) seen = 1'b1;
    end
    chk("ab_reach7", seen, 64'd1);
    hold_ack = 1'b0;
    dout_ready = 1'b0;
    tick();
    chk("ab_done_err", {done, err}, 64'b11);
    chk("ab_valid_drop", {dout_valid, hold_req, busy}, 64'd0);
    chk("ab_count", xq_idx.size(), 64'd7);

    // Reset mid-dump
    tick();
    hold_ack = 1'b1;
    dout_ready = 1'b1;
    start(0, 31);
    for (int c = 0; c < 10; c++) tick();
    chk("rm_busy_before", {busy, hold_req}, 64'b11);
    clear_mon();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rm_outputs", {hold_req, rf_rd_en, dout_valid, dout_last, busy, done, err}, 64'd0);
    chk("rm_addr_data", {rf_T_addr, dout_idx, dout_data}, 64'd0);
    for (int c = 0; c < 5; c++) tick();
    chk("rm_no_done", done_cnt, 64'd0);

    // Boundary 31..31, plus a request while busy that must be ignored
    clear_mon();
    start(31, 31);
    start(0, 0);
    wait_done(50, 0, seen, e, cyc);
    chk("b31_done_err", {seen, e}, 64'b10);
    chk("b31_count", xq_idx.size(), 64'd1);
    if (xq_idx.size() > 0) begin
      chk("b31_idx", xq_idx[0], 64'd31);
      chk("b31_data", xq_data[0], rval(31));
      chk("b31_last", xq_last[0], 64'd1);
    end
    chk("b31_no_wrap", rf_T_addr, 64'd31);
    for (int c = 0; c < 5; c++) tick();
    chk("b31_single", {done_cnt, rd_cnt}, {32'd1, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
